sim_time_ctrl: RTL

- Upstream pacing stage for the wind-turbine model.
- Generates the shared sim_time word consumed by the wind-speed profile generator and the other stages.
- Issues one step_start pulse per solver timestep, holds each step to a fixed real-time cycle budget, waits for the solver's completion pulse, and flags overruns.
- Runs from start until the configured end time, supporting pause between steps.

---
 rtl/sim_time_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sim_time_ctrl.sv
// Simulation-time pacing stage: issues one step_start per solver timestep,
// holds each step to a fixed cycle budget and flags steps whose solver overran it.
module sim_time_ctrl #(
  parameter int unsigned TIME_W      = 32,
  parameter int unsigned TIME_INC    = 1,
  parameter int unsigned T_END       = 1000000,
  parameter int unsigned STEP_CYCLES = 64,
  parameter int unsigned OVR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              solver_done,
  output logic [TIME_W-1:0] sim_time,
  output logic              step_start,
  output logic              running,
  output logic              finished,
  output logic              overrun,
  output logic [OVR_W-1:0]  overrun_cnt
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [TIME_W-1:0] TIME_STEP = TIME_W'(TIME_INC);
  // Once sim_time reaches this value another increment would pass T_END.
  localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(T_END - TIME_INC + 1);
  localparam logic [OVR_W-1:0]  OVR_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  sim_time_q, sim_time_d;
  logic               step_start_q, step_start_d;
  logic               running_q, running_d;
  logic               finished_q, finished_d;
  logic               overrun_q, overrun_d;
  logic [OVR_W-1:0]   overrun_cnt_q, overrun_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_seen_q, done_seen_d;
  logic               ovr_flag_q, ovr_flag_d;
  logic               done_now;
  logic               at_max;

  // A completion pulse coincident with the step launch belongs to no step.
  assign done_now = solver_done && !step_start_q;
  assign at_max   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    sim_time_d    = sim_time_q;
    step_start_d  = 1'b0;
    running_d     = running_q;
    finished_d    = finished_q;
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    cnt_d         = cnt_q;
    done_seen_d   = done_seen_q;
    ovr_flag_d    = ovr_flag_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_WAIT;
          sim_time_d    = '0;
          step_start_d  = 1'b1;
          running_d     = 1'b1;
          finished_d    = 1'b0;
          overrun_d     = 1'b0;
          overrun_cnt_d = '0;
          cnt_d         = '0;
          done_seen_d   = 1'b0;
          ovr_flag_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (!at_max) cnt_d = cnt_q + CNT_W'(1);
        if (done_now) done_seen_d = 1'b1;
        if (at_max && (done_seen_q || done_now)) begin
          if (sim_time_q >= TIME_LAST) begin
            state_d    = S_DONE;
            running_d  = 1'b0;
            finished_d = 1'b1;
          end else if (pause) begin
            state_d = S_HOLD;
          end else begin
            sim_time_d   = sim_time_q + TIME_STEP;
            step_start_d = 1'b1;
            cnt_d        = '0;
            done_seen_d  = 1'b0;
            ovr_flag_d   = 1'b0;
          end
        end else if (at_max && !ovr_flag_q) begin
          // Budget exhausted without a completion: account once per step.
          overrun_d  = 1'b1;
          ovr_flag_d = 1'b1;
          if (overrun_cnt_q != OVR_MAX) overrun_cnt_d = overrun_cnt_q + OVR_W'(1);
        end
      end
      S_HOLD: begin
        if (!pause) begin
          state_d      = S_WAIT;
          sim_time_d   = sim_time_q + TIME_STEP;
          step_start_d = 1'b1;
          cnt_d        = '0;
          done_seen_d  = 1'b0;
          ovr_flag_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sim_time_q    <= '0;
      step_start_q  <= 1'b0;
      running_q     <= 1'b0;
      finished_q    <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      cnt_q         <= '0;
      done_seen_q   <= 1'b0;
      ovr_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sim_time_q    <= sim_time_d;
      step_start_q  <= step_start_d;
      running_q     <= running_d;
      finished_q    <= finished_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      cnt_q         <= cnt_d;
      done_seen_q   <= done_seen_d;
      ovr_flag_q    <= ovr_flag_d;
    end
  end

  assign sim_time    = sim_time_q;
  assign step_start  = step_start_q;
  assign running     = running_q;
  assign finished    = finished_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule
